conv_window_gen: RTL and testbench
==================================

# conv_window_gen

Input stage of the gobor Gabor/CNN convolution datapath. On `start` it scans one input feature map out of the synchronous input-feature memory in raster order and pushes each pixel through two line buffers. It presents every fully populated 3x3 window (valid padding) to the downstream conv stage as a one-cycle `win_valid` beat. All progress is gated by the same `enable` that drives the conv top.

## Interface
- `DATA_WIDTH`, 16, pixel width.
- `IN_FEATURE_ADDR_WIDTH`, 9, input-feature memory address width.
- `IMG_WIDTH`, 16, pixels per row; must be >= 3.
- `IMG_HEIGHT`, 16, rows per map; must be >= 3; `IMG_WIDTH*IMG_HEIGHT` must be <= 2^`IN_FEATURE_ADDR_WIDTH`.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset).
- `enable`  in  1  global advance qualifier.
- `start`  in  1  begin one frame; sampled only in IDLE with `enable`=1.
- `mem_rd_en`  out  1  read strobe to input-feature memory.
- `mem_addr`  out  `IN_FEATURE_ADDR_WIDTH`  read address.
- `mem_rd_data`  in  `DATA_WIDTH`  read data; valid 1 cycle after `mem_rd_en`; memory holds it while `mem_rd_en`=0.
- `win_data`  out  9*`DATA_WIDTH`  window; slice i = w[row*3+col]; w0 is top-left (oldest), w8 is bottom-right (newest).
- `win_valid`  out  1  one cycle per window.
- `win_row`  out  $clog2(`IMG_HEIGHT`)  row of w8.
- `win_col`  out  $clog2(`IMG_WIDTH`)  column of w8.
- `busy`  out  1  state != IDLE.
- `frame_done`  out  1  one-cycle pulse at end of frame.

## Operation
- FSM states:
  - IDLE: `start`&`enable` -> RUN, clear counters.
  - RUN: after the last pixel is captured -> DONE.
  - DONE: one cycle, `frame_done`=1 -> IDLE. `start` is ignored in RUN and DONE.
- Issue: when RUN & `enable` & issued < N (N = W*H), drive `mem_rd_en`=1 with `mem_addr`=issue count. Issue count increments and `rd_pending` is set.
- Capture: when `enable` & `rd_pending`, take `mem_rd_data`:
  - shift it into window column 2 and line buffer 0;
  - line buffer 0 output feeds line buffer 1 and window row 1;
  - line buffer 1 output feeds window row 0;
  - all window columns shift left;
  - update the capture row/col counters, which wrap the column at W-1.
- Issue and capture may happen on the same edge, so the pipeline runs 1 pixel/cycle.
- `win_valid` is registered on the capture edge, set iff the captured row >= 2 and column >= 2. Windows at columns 0 and 1 straddle the previous row and are suppressed.
- `enable`=0 freezes everything: counters, FSM, window, line buffers and `rd_pending`. `mem_rd_en`=0 and `win_valid`=0 while frozen. An in-flight read is captured on the first cycle `enable` returns.
- `reset`=0 on any edge, including mid-frame:
  - IDLE; all counters, window, line buffers and `rd_pending` cleared;
  - all outputs 0; a pending read is discarded.
- Reset values: every output 0.

## Timing
- Edge E0 samples `start` (enable continuously high).
- Pixel k is issued at edge E(k+1) and captured at edge E(k+2).
- Window with w8 at (r,c) is visible after edge E(r*W+c+2).
- Defaults: first window after E36, last after E257, `frame_done` high after E258 for one cycle, `busy` low after E259.
- Windows per frame: (H-2)*(W-2) = 196.
- Latency from capture to `win_valid`/`win_data` is 1 cycle. No backpressure: the consumer must accept every beat.

## Structure
- Shared package `gobor_pkg` holds:
  - `DATA_WIDTH`, `IN_FEATURE_ADDR_WIDTH`, `KERNEL_SIZE`=3;
  - the FSM state typedef (IDLE/RUN/DONE);
  - the window index constants.
- One sub-module, `conv_line_buffer`: `IMG_WIDTH`-deep, `DATA_WIDTH`-wide shift delay line with a shift-enable, instantiated twice.
- Parameter legality is checked at elaboration.

## Test plan
- Ramp frame, mem[k]=k, 16x16, `enable`=1, `start` at E0:
  - first `win_valid` after E36 with (`win_row`,`win_col`)=(2,2) and w0..w8 = 0,1,2,16,17,18,32,33,34;
  - last window after E257 at (15,15) = 221,222,223,237,238,239,253,254,255;
  - exactly 196 beats; `frame_done` after E258.
- Enable gaps: drop `enable` for 5 cycles at E50 and for 1 cycle at E120 -> the window sequence is identical to the ramp case, each beat delayed by the accumulated stall. No beats and no `mem_rd_en` while `enable`=0.
- Reset mid-frame: `reset`=0 at E100 -> all outputs 0 after that edge and state is IDLE. A new `start` then yields the full correct 196-beat frame.
- `start` pulsed during RUN and during DONE -> ignored. `start` in the IDLE cycle right after DONE -> second frame with the same sequence.
- Non-square 5x3 map with mem[k]=100+k -> exactly 3 windows at (2,2),(2,3),(2,4). First window = 100,101,102,105,106,107,110,111,112.

Source files
------------

// File: rtl/gobor_pkg.sv
// Shared constants and types for the gobor convolution datapath.
package gobor_pkg;

  localparam int DATA_WIDTH            = 16;
  localparam int IN_FEATURE_ADDR_WIDTH = 9;
  localparam int KERNEL_SIZE           = 3;
  localparam int WIN_TAPS              = KERNEL_SIZE * KERNEL_SIZE;

  // Window tap indices: slice i = w[row*3+col], w0 oldest (top-left).
  localparam int WIN_TOP_NEW = 2;  // row 0, newest column, fed by line buffer 1
  localparam int WIN_MID_NEW = 5;  // row 1, newest column, fed by line buffer 0
  localparam int WIN_BOT_NEW = 8;  // row 2, newest column, fed by memory data

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } win_state_e;

  // Flat tap index of window position (row, col).
  function automatic int win_idx(input int row, input int col);
    return row * KERNEL_SIZE + col;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// DEPTH-deep shift delay line: dout is the sample shifted in DEPTH shifts ago.
module conv_line_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps_q [DEPTH];
  logic [WIDTH-1:0] taps_d [DEPTH];

  // Next-state of the delay line: shift one slot when enabled, otherwise hold.
  always_comb begin
    taps_d = taps_q;
    if (shift_en) begin
      taps_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        taps_d[i] = taps_q[i-1];
      end
    end else begin
      taps_d = taps_q;
    end
  end

  // Delay-line storage with synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        taps_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      taps_q <= taps_d;
    end
  end

  assign dout = taps_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Raster-scans one input feature map from memory and emits every complete
// 3x3 window (valid padding) as a single-cycle beat.
module conv_window_gen #(
  parameter int DATA_WIDTH            = gobor_pkg::DATA_WIDTH,
  parameter int IN_FEATURE_ADDR_WIDTH = gobor_pkg::IN_FEATURE_ADDR_WIDTH,
  parameter int IMG_WIDTH             = 16,
  parameter int IMG_HEIGHT            = 16
) (
  input  logic                                           clock,
  input  logic                                           reset,
  input  logic                                           enable,
  input  logic                                           start,
  output logic                                           mem_rd_en,
  output logic [IN_FEATURE_ADDR_WIDTH-1:0]               mem_addr,
  input  logic [DATA_WIDTH-1:0]                          mem_rd_data,
  output logic [gobor_pkg::WIN_TAPS*DATA_WIDTH-1:0]      win_data,
  output logic                                           win_valid,
  output logic [$clog2(IMG_HEIGHT)-1:0]                  win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]                   win_col,
  output logic                                           busy,
  output logic                                           frame_done
);

  import gobor_pkg::*;

  localparam int CNT_W = IN_FEATURE_ADDR_WIDTH + 1;
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int COL_W = $clog2(IMG_WIDTH);

  localparam logic [CNT_W-1:0] N_PIX     = CNT_W'(IMG_WIDTH * IMG_HEIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1'b1);
  localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1'b1);
  localparam logic [ROW_W-1:0] FIRST_WR  = ROW_W'(KERNEL_SIZE - 1);
  localparam logic [COL_W-1:0] FIRST_WC  = COL_W'(KERNEL_SIZE - 1);

  // Reject geometries the window scan cannot handle.
  if (IMG_WIDTH < KERNEL_SIZE) begin : g_chk_width
    $error("conv_window_gen: IMG_WIDTH must be >= 3");
  end
  if (IMG_HEIGHT < KERNEL_SIZE) begin : g_chk_height
    $error("conv_window_gen: IMG_HEIGHT must be >= 3");
  end
  if (IMG_WIDTH * IMG_HEIGHT > (1 << IN_FEATURE_ADDR_WIDTH)) begin : g_chk_addr
    $error("conv_window_gen: feature map does not fit the address space");
  end

  win_state_e             state_q,      state_d;
  logic [CNT_W-1:0]       issue_cnt_q,  issue_cnt_d;
  logic                   rd_pending_q, rd_pending_d;
  logic [ROW_W-1:0]       cap_row_q,    cap_row_d;
  logic [COL_W-1:0]       cap_col_q,    cap_col_d;
  logic                   busy_q,       busy_d;
  logic                   frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0]  win_q [WIN_TAPS];
  logic [DATA_WIDTH-1:0]  win_d [WIN_TAPS];
  logic                   win_valid_q,  win_valid_d;
  logic [ROW_W-1:0]       win_row_q,    win_row_d;
  logic [COL_W-1:0]       win_col_q,    win_col_d;

  logic                   issue_fire_s;
  logic                   capture_s;
  logic                   last_cap_s;
  logic [DATA_WIDTH-1:0]  lb0_out_s;
  logic [DATA_WIDTH-1:0]  lb1_out_s;

  // Issue and capture may fire on the same edge, giving one pixel per cycle.
  assign issue_fire_s = (state_q == RUN) && enable && (issue_cnt_q < N_PIX);
  assign capture_s    = enable && rd_pending_q;
  assign last_cap_s   = capture_s && (cap_row_q == LAST_ROW) && (cap_col_q == LAST_COL);

  // Line buffer 0 delays the pixel stream by one row, line buffer 1 by two.
  conv_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (DATA_WIDTH)
  ) u_lb0 (
    .clock    (clock),
    .reset    (reset),
    .shift_en (capture_s),
    .din      (mem_rd_data),
    .dout     (lb0_out_s)
  );

  conv_line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (DATA_WIDTH)
  ) u_lb1 (
    .clock    (clock),
    .reset    (reset),
    .shift_en (capture_s),
    .din      (lb0_out_s),
    .dout     (lb1_out_s)
  );

  // Frame sequencing, read issue and capture position; all held while enable is low.
  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    rd_pending_d = rd_pending_q;
    cap_row_d    = cap_row_q;
    cap_col_d    = cap_col_q;
    busy_d       = busy_q;
    frame_done_d = frame_done_q;
    if (enable) begin
      busy_d       = (state_q != IDLE);
      frame_done_d = (state_q == DONE);
      rd_pending_d = issue_fire_s;
      if (issue_fire_s) begin
        issue_cnt_d = issue_cnt_q + CNT_ONE;
      end else begin
        issue_cnt_d = issue_cnt_q;
      end
      if (capture_s) begin
        if (cap_col_q == LAST_COL) begin
          cap_col_d = {COL_W{1'b0}};
          if (cap_row_q == LAST_ROW) begin
            cap_row_d = {ROW_W{1'b0}};
          end else begin
            cap_row_d = cap_row_q + ROW_ONE;
          end
        end else begin
          cap_col_d = cap_col_q + COL_ONE;
          cap_row_d = cap_row_q;
        end
      end else begin
        cap_col_d = cap_col_q;
        cap_row_d = cap_row_q;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d      = RUN;
            issue_cnt_d  = {CNT_W{1'b0}};
            rd_pending_d = 1'b0;
            cap_row_d    = {ROW_W{1'b0}};
            cap_col_d    = {COL_W{1'b0}};
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (last_cap_s) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Window shift: memory data enters row 2, line buffer outputs enter rows 1 and 0.
  always_comb begin
    win_d       = win_q;
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    if (enable) begin
      // Columns 0 and 1 of a row would straddle the previous row, so no beat.
      win_valid_d = capture_s && (cap_row_q >= FIRST_WR) && (cap_col_q >= FIRST_WC);
      if (capture_s) begin
        for (int r = 0; r < KERNEL_SIZE; r++) begin
          for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
            win_d[win_idx(r, c)] = win_q[win_idx(r, c + 1)];
          end
        end
        win_d[WIN_TOP_NEW] = lb1_out_s;
        win_d[WIN_MID_NEW] = lb0_out_s;
        win_d[WIN_BOT_NEW] = mem_rd_data;
        win_row_d          = cap_row_q;
        win_col_d          = cap_col_q;
      end else begin
        win_row_d = win_row_q;
        win_col_d = win_col_q;
      end
    end else begin
      win_valid_d = win_valid_q;
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      issue_cnt_q  <= {CNT_W{1'b0}};
      rd_pending_q <= 1'b0;
      cap_row_q    <= {ROW_W{1'b0}};
      cap_col_q    <= {COL_W{1'b0}};
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      rd_pending_q <= rd_pending_d;
      cap_row_q    <= cap_row_d;
      cap_col_q    <= cap_col_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Window and beat registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < WIN_TAPS; i++) begin
        win_q[i] <= {DATA_WIDTH{1'b0}};
      end
      win_valid_q <= 1'b0;
      win_row_q   <= {ROW_W{1'b0}};
      win_col_q   <= {COL_W{1'b0}};
    end else begin
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

  for (genvar gi = 0; gi < WIN_TAPS; gi++) begin : g_pack
    assign win_data[gi*DATA_WIDTH +: DATA_WIDTH] = win_q[gi];
  end

  // Held beats are masked while frozen and reappear when enable returns.
  assign mem_rd_en  = issue_fire_s;
  assign mem_addr   = issue_cnt_q[IN_FEATURE_ADDR_WIDTH-1:0];
  assign win_valid  = win_valid_q && enable;
  assign frame_done = frame_done_q && enable;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: 16x16 ramp frames and a 5x3 map.
module tb_conv_window_gen;

  localparam int DW = 16;
  localparam int AW = 9;
  localparam int W  = 16;
  localparam int H  = 16;
  localparam int W2 = 5;
  localparam int H2 = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, enable, start, start2;

  logic          mem_rd_en, win_valid, busy, frame_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data = 16'd0;
  logic [9*DW-1:0] win_data;
  logic [3:0]    win_row, win_col;

  logic          mem_rd_en2, win_valid2, busy2, frame_done2;
  logic [AW-1:0] mem_addr2;
  logic [DW-1:0] mem_rd_data2 = 16'd0;
  logic [9*DW-1:0] win_data2;
  logic [1:0]    win_row2;
  logic [2:0]    win_col2;

  int n_cmp = 0;
  int n_fail = 0;

  conv_window_gen #(.DATA_WIDTH(DW), .IN_FEATURE_ADDR_WIDTH(AW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .win_data(win_data), .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
    .busy(busy), .frame_done(frame_done)
  );

  conv_window_gen #(.DATA_WIDTH(DW), .IN_FEATURE_ADDR_WIDTH(AW), .IMG_WIDTH(W2), .IMG_HEIGHT(H2)) dut2 (
    .clock(clock), .reset(reset), .enable(enable), .start(start2),
    .mem_rd_en(mem_rd_en2), .mem_addr(mem_addr2), .mem_rd_data(mem_rd_data2),
    .win_data(win_data2), .win_valid(win_valid2), .win_row(win_row2), .win_col(win_col2),
    .busy(busy2), .frame_done(frame_done2)
  );

  // Synchronous memories: mem[k]=k for the 16x16 map, mem[k]=100+k for the 5x3 map.
  always @(posedge clock) begin
    if (mem_rd_en) mem_rd_data <= {7'd0, mem_addr};
    if (mem_rd_en2) mem_rd_data2 <= 16'd100 + {7'd0, mem_addr2};
  end

  // Runs one 16x16 ramp frame. Entered and left #1 after a rising edge.
  // Iteration e drives the inputs for edge Ee and samples the state after E(e-1).
  task automatic run_ramp_frame(input bit stalls, input bit extra_starts,
                                input bit chain_next, input bit pre_started, input string tag);
    int nbeats, ndone, st_tot, last_e, s, r, c, exp_edge;
    logic [DW-1:0] exp_px;
    nbeats = 0; ndone = 0;
    st_tot = stalls ? 6 : 0;
    last_e = chain_next ? 259 : 260 + st_tot;
    for (int e = (pre_started ? 1 : 0); e <= last_e; e++) begin
      s = e - 1;
      enable = !(stalls && ((e >= 50 && e <= 54) || e == 120));
      start  = (e == 0) || (extra_starts && (e == 80 || e == 258)) || (chain_next && e == 259);
      #1;
      if (e >= 1) begin
        if (win_valid === 1'b1) begin
          r = 2 + nbeats / (W - 2);
          c = 2 + nbeats % (W - 2);
          n_cmp++;
          if (win_row !== 4'(r) || win_col !== 4'(c)) begin
            n_fail++;
            $display("FAIL %s pos beat %0d: got (%0d,%0d) expected (%0d,%0d)", tag, nbeats, win_row, win_col, r, c);
          end
          for (int i = 0; i < 9; i++) begin
            exp_px = 16'((r - 2 + i / 3) * W + (c - 2 + i % 3));
            n_cmp++;
            if (win_data[i*DW +: DW] !== exp_px) begin
              n_fail++;
              $display("FAIL %s w%0d beat %0d: got %0d expected %0d", tag, i, nbeats, win_data[i*DW +: DW], exp_px);
            end
          end
          if (!stalls) begin
            exp_edge = r * W + c + 2;
            n_cmp++;
            if (s != exp_edge) begin
              n_fail++;
              $display("FAIL %s beat_edge %0d: got E%0d expected E%0d", tag, nbeats, s, exp_edge);
            end
          end
          nbeats++;
        end
        if (!enable) begin
          n_cmp++;
          if (win_valid !== 1'b0 || mem_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL %s frozen_outputs at E%0d: got valid=%b rd_en=%b expected 0 0", tag, s, win_valid, mem_rd_en);
          end
        end
        if (frame_done === 1'b1) begin
          ndone++;
          n_cmp++;
          if (s != 258 + st_tot) begin
            n_fail++;
            $display("FAIL %s frame_done_edge: got E%0d expected E%0d", tag, s, 258 + st_tot);
          end
        end
        if (!chain_next && s == 258 + st_tot) begin
          n_cmp++;
          if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_at_done: got %b expected 1", tag, busy);
          end
        end
        if (!chain_next && s == 259 + st_tot) begin
          n_cmp++;
          if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_after_done: got %b expected 0", tag, busy);
          end
        end
      end
      @(posedge clock); #1;
    end
    start  = 1'b0;
    enable = 1'b1;
    n_cmp++;
    if (nbeats != 196) begin
      n_fail++;
      $display("FAIL %s beat_count: got %0d expected 196", tag, nbeats);
    end
    n_cmp++;
    if (ndone != 1) begin
      n_fail++;
      $display("FAIL %s frame_done_count: got %0d expected 1", tag, ndone);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; start = 1'b0; start2 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (win_valid !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0 || mem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got valid=%b done=%b busy=%b rd_en=%b expected all 0", win_valid, frame_done, busy, mem_rd_en);
    end
    n_cmp++;
    if (win_data !== '0 || mem_addr !== '0 || win_row !== 4'd0 || win_col !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_data: got data=%h addr=%0d row=%0d col=%0d expected all 0", win_data, mem_addr, win_row, win_col);
    end
    n_cmp++;
    if (win_valid2 !== 1'b0 || busy2 !== 1'b0 || mem_rd_en2 !== 1'b0 || win_data2 !== '0) begin
      n_fail++;
      $display("FAIL reset_small: got valid=%b busy=%b rd_en=%b data=%h expected all 0", win_valid2, busy2, mem_rd_en2, win_data2);
    end
  endtask

  task automatic test_ramp();
    run_ramp_frame(1'b0, 1'b0, 1'b0, 1'b0, "ramp");
  endtask

  task automatic test_enable_gaps();
    run_ramp_frame(1'b1, 1'b0, 1'b0, 1'b0, "gaps");
  endtask

  task automatic test_reset_mid_frame();
    for (int e = 0; e <= 100; e++) begin
      enable = 1'b1;
      start  = (e == 0);
      reset  = (e == 100) ? 1'b0 : 1'b1;
      #1;
      if (e == 100) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL midreset_busy_before: got %b expected 1", busy);
        end
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
    #1;
    n_cmp++;
    if (win_valid !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0 || mem_rd_en !== 1'b0 || mem_addr !== '0) begin
      n_fail++;
      $display("FAIL midreset_ctrl: got valid=%b done=%b busy=%b rd_en=%b addr=%0d expected all 0", win_valid, frame_done, busy, mem_rd_en, mem_addr);
    end
    n_cmp++;
    if (win_data !== '0 || win_row !== 4'd0 || win_col !== 4'd0) begin
      n_fail++;
      $display("FAIL midreset_data: got data=%h row=%0d col=%0d expected all 0", win_data, win_row, win_col);
    end
    reset = 1'b1;
    @(posedge clock); #2;
    n_cmp++;
    if (mem_rd_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_idle: got rd_en=%b busy=%b expected 0 0", mem_rd_en, busy);
    end
    run_ramp_frame(1'b0, 1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_start_ignored();
    run_ramp_frame(1'b0, 1'b1, 1'b1, 1'b0, "start_ignored");
    run_ramp_frame(1'b0, 1'b0, 1'b0, 1'b1, "second_frame");
  endtask

  task automatic test_small_map();
    int nbeats, ndone, s, c;
    logic [DW-1:0] exp_px;
    nbeats = 0; ndone = 0;
    for (int e = 0; e <= 20; e++) begin
      s = e - 1;
      enable = 1'b1;
      start2 = (e == 0);
      #1;
      if (e >= 1) begin
        if (win_valid2 === 1'b1) begin
          c = 2 + nbeats;
          n_cmp++;
          if (win_row2 !== 2'd2 || win_col2 !== 3'(c) || s != 2 * W2 + c + 2) begin
            n_fail++;
            $display("FAIL small_pos beat %0d: got (%0d,%0d)@E%0d expected (2,%0d)@E%0d", nbeats, win_row2, win_col2, s, c, 2 * W2 + c + 2);
          end
          for (int i = 0; i < 9; i++) begin
            exp_px = 16'(100 + (i / 3) * W2 + (c - 2 + i % 3));
            n_cmp++;
            if (win_data2[i*DW +: DW] !== exp_px) begin
              n_fail++;
              $display("FAIL small_w%0d beat %0d: got %0d expected %0d", i, nbeats, win_data2[i*DW +: DW], exp_px);
            end
          end
          nbeats++;
        end
        if (frame_done2 === 1'b1) begin
          ndone++;
          n_cmp++;
          if (s != 17) begin
            n_fail++;
            $display("FAIL small_done_edge: got E%0d expected E17", s);
          end
        end
      end
      @(posedge clock); #1;
    end
    start2 = 1'b0;
    n_cmp++;
    if (nbeats != 3 || ndone != 1) begin
      n_fail++;
      $display("FAIL small_counts: got beats=%0d done=%0d expected 3 1", nbeats, ndone);
    end
    n_cmp++;
    if (busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL small_busy_end: got %b expected 0", busy2);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_enable_gaps();
    test_reset_mid_frame();
    test_start_ignored();
    test_small_map();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
